// File: rtl/leg_calc_sequencer_if.sv
// Command and leg-vector bus between the tilt controller, leg_calc and the actuator stage.
// The master drives commands and the leg vector; the slave is the sequencer.
interface leg_calc_sequencer_if;
    logic               cmd_valid;
    logic               cmd_ready;
    logic signed [7:0]  cmd_angle_x;
    logic signed [7:0]  cmd_angle_y;
    logic signed [7:0]  calc_angle_x;
    logic signed [7:0]  calc_angle_y;
    logic [50:0]        calc_leg_vector;
    logic signed [16:0] leg_x;
    logic signed [16:0] leg_y;
    logic signed [16:0] leg_z;
    logic [34:0]        leg_len2;
    logic               leg_valid;
    logic               fault;

    modport master (
        output cmd_valid, cmd_angle_x, cmd_angle_y, calc_leg_vector,
        input  cmd_ready, calc_angle_x, calc_angle_y,
        input  leg_x, leg_y, leg_z, leg_len2, leg_valid, fault
    );

    modport slave (
        input  cmd_valid, cmd_angle_x, cmd_angle_y, calc_leg_vector,
        output cmd_ready, calc_angle_x, calc_angle_y,
        output leg_x, leg_y, leg_z, leg_len2, leg_valid, fault
    );
endinterface

// File: rtl/leg_calc_sequencer.sv
// Sequences the leg_calc datapath: clamps and slew-limits plate angles, waits for the
// pipeline, squares the leg vector with one shared multiplier and window-checks the length.
module leg_calc_sequencer #(
    parameter int unsigned CALC_LATENCY = 4,
    parameter int unsigned MAX_ANGLE    = 30,
    parameter int unsigned MAX_STEP     = 5,
    parameter logic [34:0] LEN2_MIN     = 35'd0,
    parameter logic [34:0] LEN2_MAX     = 35'h3_FFFF_FFFF
) (
    input  logic                clock,
    input  logic                reset_n,
    leg_calc_sequencer_if.slave seq_if
);
    localparam int unsigned ANG_W  = 8;
    localparam int unsigned EXT_W  = 9;
    localparam int unsigned COMP_W = 17;
    localparam int unsigned PROD_W = 34;
    localparam int unsigned LEN_W  = 35;
    localparam int unsigned CNT_W  = (CALC_LATENCY > 1) ? $clog2(CALC_LATENCY) : 1;

    localparam logic signed [EXT_W-1:0] ANG_LIM  = EXT_W'(MAX_ANGLE);
    localparam logic signed [EXT_W-1:0] STEP_LIM = EXT_W'(MAX_STEP);
    // Window test as one unsigned compare: values below LEN2_MIN wrap to a huge offset.
    localparam logic [LEN_W:0] WIN_SPAN = (LEN_W+1)'(LEN2_MAX) - (LEN_W+1)'(LEN2_MIN);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LIMIT,
        ST_SETTLE,
        ST_CAPTURE,
        ST_SQUARE,
        ST_CHECK
    } state_e;

    state_e                    state_q;
    logic                      ready_q;
    logic signed [ANG_W-1:0]   cmd_x_q;
    logic signed [ANG_W-1:0]   cmd_y_q;
    logic signed [ANG_W-1:0]   calc_x_q;
    logic signed [ANG_W-1:0]   calc_y_q;
    logic signed [ANG_W-1:0]   good_x_q;
    logic signed [ANG_W-1:0]   good_y_q;
    logic [CNT_W-1:0]          cnt_q;
    logic signed [COMP_W-1:0]  x_q;
    logic signed [COMP_W-1:0]  y_q;
    logic signed [COMP_W-1:0]  z_q;
    logic [1:0]                sq_idx_q;
    logic [LEN_W-1:0]          acc_q;
    logic signed [COMP_W-1:0]  leg_x_q;
    logic signed [COMP_W-1:0]  leg_y_q;
    logic signed [COMP_W-1:0]  leg_z_q;
    logic [LEN_W-1:0]          len2_q;
    logic                      valid_q;
    logic                      fault_q;

    logic signed [ANG_W-1:0]   calc_x_d;
    logic signed [ANG_W-1:0]   calc_y_d;
    logic signed [COMP_W-1:0]  mul_op;
    logic signed [PROD_W-1:0]  mul_ext;
    logic signed [PROD_W-1:0]  prod_c;
    logic                      in_window;

    function automatic logic signed [EXT_W-1:0] sat9(
        input logic signed [EXT_W-1:0] v,
        input logic signed [EXT_W-1:0] lim
    );
        logic signed [EXT_W-1:0] r;
        r = v;
        if (v > lim) begin
            r = lim;
        end else if (v < -lim) begin
            r = -lim;
        end
        return r;
    endfunction

    function automatic logic signed [ANG_W-1:0] slew(
        input logic signed [ANG_W-1:0] cmd,
        input logic signed [ANG_W-1:0] good
    );
        logic signed [EXT_W-1:0] clamped;
        logic signed [EXT_W-1:0] good9;
        logic signed [EXT_W-1:0] delta;
        logic signed [EXT_W-1:0] next;
        clamped = sat9({cmd[ANG_W-1], cmd}, ANG_LIM);
        good9   = {good[ANG_W-1], good};
        delta   = sat9(clamped - good9, STEP_LIM);
        next    = good9 + delta;
        return next[ANG_W-1:0];
    endfunction

    // Clamped, slew-limited angles for the LIMIT state.
    always_comb begin
        calc_x_d = slew(cmd_x_q, good_x_q);
        calc_y_d = slew(cmd_y_q, good_y_q);
    end

    // Shared squarer: x, y, z in successive SQUARE cycles.
    always_comb begin
        mul_op = z_q;
        case (sq_idx_q)
            2'd0:    mul_op = x_q;
            2'd1:    mul_op = y_q;
            default: mul_op = z_q;
        endcase
        mul_ext = PROD_W'(mul_op);
        prod_c  = mul_ext * mul_ext;
    end

    assign in_window = ((LEN_W+1)'(acc_q) - (LEN_W+1)'(LEN2_MIN)) <= WIN_SPAN;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            ready_q  <= 1'b1;
            cmd_x_q  <= '0;
            cmd_y_q  <= '0;
            calc_x_q <= '0;
            calc_y_q <= '0;
            good_x_q <= '0;
            good_y_q <= '0;
            cnt_q    <= '0;
            x_q      <= '0;
            y_q      <= '0;
            z_q      <= '0;
            sq_idx_q <= '0;
            acc_q    <= '0;
            leg_x_q  <= '0;
            leg_y_q  <= '0;
            leg_z_q  <= '0;
            len2_q   <= '0;
            valid_q  <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (seq_if.cmd_valid) begin
                        cmd_x_q <= seq_if.cmd_angle_x;
                        cmd_y_q <= seq_if.cmd_angle_y;
                        ready_q <= 1'b0;
                        state_q <= ST_LIMIT;
                    end
                end
                ST_LIMIT: begin
                    calc_x_q <= calc_x_d;
                    calc_y_q <= calc_y_d;
                    cnt_q    <= CNT_W'(CALC_LATENCY - 1);
                    state_q  <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (cnt_q == '0) begin
                        state_q <= ST_CAPTURE;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                ST_CAPTURE: begin
                    x_q      <= seq_if.calc_leg_vector[16:0];
                    y_q      <= seq_if.calc_leg_vector[33:17];
                    z_q      <= seq_if.calc_leg_vector[50:34];
                    acc_q    <= '0;
                    sq_idx_q <= '0;
                    state_q  <= ST_SQUARE;
                end
                ST_SQUARE: begin
                    acc_q <= acc_q + {1'b0, prod_c};
                    if (sq_idx_q == 2'd2) begin
                        state_q <= ST_CHECK;
                    end else begin
                        sq_idx_q <= sq_idx_q + 2'd1;
                    end
                end
                ST_CHECK: begin
                    if (in_window) begin
                        leg_x_q  <= x_q;
                        leg_y_q  <= y_q;
                        leg_z_q  <= z_q;
                        len2_q   <= acc_q;
                        valid_q  <= 1'b1;
                        fault_q  <= 1'b0;
                        good_x_q <= calc_x_q;
                        good_y_q <= calc_y_q;
                    end else begin
                        fault_q  <= 1'b1;
                        calc_x_q <= good_x_q;
                        calc_y_q <= good_y_q;
                    end
                    ready_q <= 1'b1;
                    state_q <= ST_IDLE;
                end
                default: begin
                    ready_q <= 1'b1;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign seq_if.cmd_ready    = ready_q;
    assign seq_if.calc_angle_x = calc_x_q;
    assign seq_if.calc_angle_y = calc_y_q;
    assign seq_if.leg_x        = leg_x_q;
    assign seq_if.leg_y        = leg_y_q;
    assign seq_if.leg_z        = leg_z_q;
    assign seq_if.leg_len2     = len2_q;
    assign seq_if.leg_valid    = valid_q;
    assign seq_if.fault        = fault_q;

endmodule

// File: doc/leg_calc_sequencer.md
# leg_calc_sequencer

Sequences the leg-vector datapath (`leg_calc`) for the ball-and-plate platform. It accepts plate-angle commands from the tilt controller over a valid/ready handshake, then clamps and slew-limits the angles before driving them into `leg_calc`. After the datapath pipeline settles, it captures the packed leg vector and computes the squared leg length with one shared multiplier. Results inside the length window go to the actuator stage; results outside it are rejected and the drive falls back to the last good angles.

## Interface
Parameters:
- `CALC_LATENCY`, 4: clock cycles from a change on `calc_angle_*` until `calc_leg_vector` is valid (≥1).
- `MAX_ANGLE`, 30: symmetric angle clamp, degrees (1..127).
- `MAX_STEP`, 5: maximum per-command angle change, degrees (1..127).
- `LEN2_MIN`, 0: minimum legal squared length, 35-bit unsigned.
- `LEN2_MAX`, 35'h3_FFFF_FFFF: maximum legal squared length, 35-bit unsigned.

Ports:
- `clock` in 1: sole clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: block can accept a command.
- `cmd_angle_x`, `cmd_angle_y` in 8: signed requested angles, degrees.
- `calc_angle_x`, `calc_angle_y` out 8: signed angles driven to `leg_calc`.
- `calc_leg_vector` in 51: packed {z[50:34], y[33:17], x[16:0]}, each 17-bit signed.
- `leg_x`, `leg_y`, `leg_z` out 17: signed accepted components.
- `leg_len2` out 35: unsigned x²+y²+z² of the accepted result.
- `leg_valid` out 1: one-cycle pulse when the leg outputs update.
- `fault` out 1: the last completed check failed.

## Operation
- The FSM has the states IDLE, LIMIT, SETTLE, CAPTURE, SQUARE and CHECK.
- `cmd_ready` = (state == IDLE). A command is accepted on a clock edge where `cmd_valid & cmd_ready` is true.
- Accepting a command registers both angles and moves IDLE → LIMIT. `cmd_valid` in any other state is ignored; it is neither latched nor queued.
- LIMIT performs the following, using 9-bit signed arithmetic throughout (so -128 is handled):
  - Clamp each angle to [-MAX_ANGLE, +MAX_ANGLE].
  - Compute delta = clamped − last_good and clamp delta to [-MAX_STEP, +MAX_STEP].
  - Register last_good + delta onto `calc_angle_*`.
  - Go to SETTLE with the counter loaded to CALC_LATENCY−1.
- SETTLE decrements the counter each cycle and goes to CAPTURE when the counter is 0. The state therefore lasts exactly CALC_LATENCY cycles.
- CAPTURE registers `calc_leg_vector` into internal x, y, z and clears the accumulator.
- SQUARE lasts 3 cycles with one 17×17 signed multiplier, squaring x, then y, then z in that order. Each product (≤2^32) is added to the 35-bit unsigned accumulator. The sum cannot overflow 35 bits.
- CHECK passes when LEN2_MIN ≤ acc ≤ LEN2_MAX.
  - Pass: update `leg_x/y/z` and `leg_len2`, pulse `leg_valid`, clear `fault`, and set last_good = `calc_angle_*`.
  - Fail: hold the leg outputs, do not pulse `leg_valid`, set `fault`, and restore `calc_angle_*` to last_good.
  - Either way, go to IDLE.
- `fault` stays high until the next passing check.
- last_good resets to 0/0. The first command slews from 0.

## Timing
- Reset values while `reset_n` is low:
  - state IDLE, so `cmd_ready` = 1.
  - `calc_angle_*` = 0, last_good = 0.
  - `leg_*` = 0, `leg_len2` = 0, `leg_valid` = 0, `fault` = 0.
- Reset assertion takes effect immediately. Reset in mid-operation discards the in-flight command, and no `leg_valid` is produced for it.
- `calc_angle_*` changes on the edge that ends LIMIT, which is 1 cycle after accept. It holds stable for the whole of SETTLE, CAPTURE, SQUARE and CHECK.
- Latency from the accept edge to `leg_valid` high = CALC_LATENCY + 6 cycles (10 at the defaults).
- `cmd_ready` rises in the same cycle as `leg_valid` (or as the `fault` update). The next command can therefore be accepted on the edge that ends that cycle.
- Sustained throughput is one command per CALC_LATENCY + 6 cycles.
- `leg_valid` is high for exactly one cycle per passing check and is never high in two consecutive cycles.

## Test plan
- **Basic:** use `calc_leg_vector` stub x=3, y=4, z=12 and command (2, −3) → `calc_angle` = (2, −3) one cycle after accept. `leg_valid` follows 10 cycles after accept with `leg_len2` = 169, `fault` = 0.
- **Clamp and slew:** with last_good = (0, 0), send command (100, −128) → `calc_angle` = (5, −5). Repeating the command 6 times more walks the angles to (30, −30) and they stay there.
- **Window fault:** set LEN2_MAX = 100 with stub x=y=z=10 (len2 = 300) → no `leg_valid`, `fault` = 1, outputs hold their prior values and `calc_angle` reverts to last_good. The next passing result clears `fault`.
- **Busy:** hold `cmd_valid` with changing angles during SETTLE → only the accepted command is processed. `cmd_ready` = 0 from accept+1 until the result cycle.
- **Reset mid-SQUARE:** pull `reset_n` low → all outputs go to 0 asynchronously, no `leg_valid` appears, and `cmd_ready` = 1.
- **Extremes:** stub x=y=z = −65536 → `leg_len2` = 3×2^32 = 35'h3_0000_0000, with no overflow.
